// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT post-butterfly datapath.
// Defaults describe a 1024-point FFT with 16-bit components and Q1.15 twiddles.
package fft_pkg;

    localparam int unsigned COMP_BW_DEF = 32;
    localparam int unsigned TW_BW_DEF   = 16;
    localparam int unsigned N_LOG2_DEF  = 10;

    // Input beat to out_valid, counted in advance-enable cycles.
    localparam int unsigned TWS_LAT = 3;

    // Per-component width of a packed {re,im} word.
    function automatic int unsigned bw_of(input int unsigned comp_bw);
        return comp_bw / 2;
    endfunction

    // Half an LSB of the twiddle scale, for round-half-up.
    function automatic longint round_half(input int unsigned tw_bw);
        return longint'(1) <<< (tw_bw - 1);
    endfunction

    function automatic longint sat_max(input int unsigned bw);
        return (longint'(1) <<< (bw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int unsigned bw);
        return -(longint'(1) <<< (bw - 1));
    endfunction

    localparam int unsigned BW         = bw_of(COMP_BW_DEF);
    localparam longint      ROUND_HALF = round_half(TW_BW_DEF);
    localparam longint      SAT_MAX    = sat_max(BW);
    localparam longint      SAT_MIN    = sat_min(BW);

endpackage

// File: rtl/bf_twiddle_scale_if.sv
// Stream bundle between the butterfly, the twiddle/scale stage and the SRAM writer.
// master drives the input beat and accepts results; slave is the stage itself.
interface bf_twiddle_scale_if #(
    parameter int unsigned COMP_BW = 32,
    parameter int unsigned N_LOG2  = 10
);
    logic                in_valid;
    logic                in_ready;
    logic [COMP_BW+1:0]  in_t;
    logic [COMP_BW+1:0]  in_y;
    logic [N_LOG2-2:0]   in_tw_idx;
    logic [N_LOG2-1:0]   in_addr_t;
    logic [N_LOG2-1:0]   in_addr_y;

    logic                out_valid;
    logic                out_ready;
    logic [COMP_BW-1:0]  out_t;
    logic [COMP_BW-1:0]  out_y;
    logic [N_LOG2-1:0]   out_addr_t;
    logic [N_LOG2-1:0]   out_addr_y;

    modport master (
        output in_valid, in_t, in_y, in_tw_idx, in_addr_t, in_addr_y, out_ready,
        input  in_ready, out_valid, out_t, out_y, out_addr_t, out_addr_y
    );

    modport slave (
        input  in_valid, in_t, in_y, in_tw_idx, in_addr_t, in_addr_y, out_ready,
        output in_ready, out_valid, out_t, out_y, out_addr_t, out_addr_y
    );
endinterface

// File: rtl/twiddle_rom.sv
// Twiddle ROM: c = round(cos(2*pi*k/N)*2^(TW_BW-1)), s = round(sin(...)*2^(TW_BW-1)),
// both clamped to the positive full scale. Table built at elaboration, registered read.
module twiddle_rom #(
    parameter int unsigned N_LOG2 = 10,
    parameter int unsigned TW_BW  = 16
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic [N_LOG2-2:0]       addr,
    output logic signed [TW_BW-1:0] cos_q,
    output logic signed [TW_BW-1:0] sin_q
);

    localparam int unsigned Depth = 2 ** (N_LOG2 - 1);
    localparam real         Pi    = 3.14159265358979323846;
    localparam real         Scale = 2.0 ** (TW_BW - 1);
    localparam longint      TwMax = (longint'(1) <<< (TW_BW - 1)) - 1;

    logic signed [TW_BW-1:0] cos_tab [Depth];
    logic signed [TW_BW-1:0] sin_tab [Depth];

    for (genvar k = 0; k < Depth; k++) begin : g_tab
        localparam real    Ang  = 2.0 * Pi * k / (2.0 ** N_LOG2);
        localparam longint CosR = longint'($floor($cos(Ang) * Scale + 0.5));
        localparam longint SinR = longint'($floor($sin(Ang) * Scale + 0.5));
        // +1.0 is not representable, so k=0 (and k=N/4 for sin) clamp to full scale.
        assign cos_tab[k] = TW_BW'((CosR > TwMax) ? TwMax : CosR);
        assign sin_tab[k] = TW_BW'((SinR > TwMax) ? TwMax : SinR);
    end

    // Synchronous read, held with the rest of the pipeline on a stall.
    always_ff @(posedge clk) begin
        if (en) begin
            cos_q <= cos_tab[addr];
            sin_q <= sin_tab[addr];
        end
    end

endmodule

// File: rtl/bf_twiddle_scale.sv
// Post-butterfly stage of a radix-2 DIF FFT: out_y = sat(round(Y*W^k / 2)),
// out_t = round(T / 2), three register stages with a global stall enable.
// Optional build macro TWS_SAT_FLAG_EN adds a sticky Y-saturation flag (sat_flag/sat_clr).
module bf_twiddle_scale
    import fft_pkg::*;
#(
    parameter int unsigned COMP_BW = COMP_BW_DEF,
    parameter int unsigned TW_BW   = TW_BW_DEF,
    parameter int unsigned N_LOG2  = N_LOG2_DEF
) (
    input  logic                clk,
    input  logic                rstn,
`ifdef TWS_SAT_FLAG_EN
    output logic                sat_flag,
    input  logic                sat_clr,
`endif
    bf_twiddle_scale_if.slave   bus
);

    localparam int unsigned BWc = bw_of(COMP_BW);
    localparam int unsigned IW  = BWc + 1;        // butterfly output component width
    localparam int unsigned PW  = IW + TW_BW;     // product width
    localparam int unsigned SW  = PW + 1;         // sum of two products
    localparam longint      RndHalf = round_half(TW_BW);
    localparam longint      SatMax  = sat_max(BWc);
    localparam longint      SatMin  = sat_min(BWc);

    logic en;

    // S0
    logic                    v0_q;
    logic signed [IW-1:0]    t0_re_q, t0_im_q, y0_re_q, y0_im_q;
    logic [N_LOG2-1:0]       at0_q, ay0_q;
    logic signed [TW_BW-1:0] cos_q, sin_q;

    // S1
    logic                    v1_q;
    logic signed [IW-1:0]    t1_re_q, t1_im_q;
    logic signed [PW-1:0]    p_rc_q, p_is_q, p_ic_q, p_rs_q;
    logic [N_LOG2-1:0]       at1_q, ay1_q;

    // S2 (output register)
    logic                    v2_q;
    logic signed [BWc-1:0]   ot_re_q, ot_im_q, oy_re_q, oy_im_q;
    logic signed [BWc-1:0]   ot_re_d, ot_im_d, oy_re_d, oy_im_d;
    logic [N_LOG2-1:0]       at2_q, ay2_q;

    logic signed [SW-1:0]    yr_sum, yi_sum, yr_rnd, yi_rnd;
    logic signed [IW:0]      tr_x, ti_x;
    logic                    sat_re, sat_im;

    // Whole pipeline advances together unless the output beat is blocked.
    assign en           = bus.out_ready | ~v2_q;
    assign bus.in_ready = en;

    twiddle_rom #(
        .N_LOG2 (N_LOG2),
        .TW_BW  (TW_BW)
    ) u_rom (
        .clk   (clk),
        .en    (en),
        .addr  (bus.in_tw_idx),
        .cos_q (cos_q),
        .sin_q (sin_q)
    );

    // S0: capture the input beat; the ROM register runs alongside.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v0_q    <= 1'b0;
            t0_re_q <= '0;
            t0_im_q <= '0;
            y0_re_q <= '0;
            y0_im_q <= '0;
            at0_q   <= '0;
            ay0_q   <= '0;
        end else if (en) begin
            v0_q    <= bus.in_valid;
            t0_re_q <= bus.in_t[2*IW-1:IW];
            t0_im_q <= bus.in_t[IW-1:0];
            y0_re_q <= bus.in_y[2*IW-1:IW];
            y0_im_q <= bus.in_y[IW-1:0];
            at0_q   <= bus.in_addr_t;
            ay0_q   <= bus.in_addr_y;
        end
    end

    // S1: the four signed partial products of Y * conj-rotated twiddle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q    <= 1'b0;
            t1_re_q <= '0;
            t1_im_q <= '0;
            p_rc_q  <= '0;
            p_is_q  <= '0;
            p_ic_q  <= '0;
            p_rs_q  <= '0;
            at1_q   <= '0;
            ay1_q   <= '0;
        end else if (en) begin
            v1_q    <= v0_q;
            t1_re_q <= t0_re_q;
            t1_im_q <= t0_im_q;
            p_rc_q  <= PW'(y0_re_q) * PW'(cos_q);
            p_is_q  <= PW'(y0_im_q) * PW'(sin_q);
            p_ic_q  <= PW'(y0_im_q) * PW'(cos_q);
            p_rs_q  <= PW'(y0_re_q) * PW'(sin_q);
            at1_q   <= at0_q;
            ay1_q   <= ay0_q;
        end
    end

    // S2 next state: combine, round half-up with the extra 1/2, saturate Y; halve T.
    always_comb begin
        yr_sum  = SW'(p_rc_q) + SW'(p_is_q);
        yi_sum  = SW'(p_ic_q) - SW'(p_rs_q);
        yr_rnd  = (yr_sum + SW'(RndHalf)) >>> TW_BW;
        yi_rnd  = (yi_sum + SW'(RndHalf)) >>> TW_BW;
        sat_re  = (yr_rnd > SW'(SatMax)) || (yr_rnd < SW'(SatMin));
        sat_im  = (yi_rnd > SW'(SatMax)) || (yi_rnd < SW'(SatMin));

        oy_re_d = BWc'(yr_rnd);
        if (yr_rnd > SW'(SatMax)) begin
            oy_re_d = BWc'(SatMax);
        end else if (yr_rnd < SW'(SatMin)) begin
            oy_re_d = BWc'(SatMin);
        end
        oy_im_d = BWc'(yi_rnd);
        if (yi_rnd > SW'(SatMax)) begin
            oy_im_d = BWc'(SatMax);
        end else if (yi_rnd < SW'(SatMin)) begin
            oy_im_d = BWc'(SatMin);
        end

        // T is a sum of two BW-bit values, so the halved result always fits.
        tr_x    = (IW+1)'(t1_re_q) + (IW+1)'(1);
        ti_x    = (IW+1)'(t1_im_q) + (IW+1)'(1);
        ot_re_d = BWc'(tr_x >>> 1);
        ot_im_d = BWc'(ti_x >>> 1);
    end

    // S2: output register, held while the downstream writer stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2_q    <= 1'b0;
            ot_re_q <= '0;
            ot_im_q <= '0;
            oy_re_q <= '0;
            oy_im_q <= '0;
            at2_q   <= '0;
            ay2_q   <= '0;
        end else if (en) begin
            v2_q    <= v1_q;
            ot_re_q <= ot_re_d;
            ot_im_q <= ot_im_d;
            oy_re_q <= oy_re_d;
            oy_im_q <= oy_im_d;
            at2_q   <= at1_q;
            ay2_q   <= ay1_q;
        end
    end

    assign bus.out_valid  = v2_q;
    assign bus.out_t      = {ot_re_q, ot_im_q};
    assign bus.out_y      = {oy_re_q, oy_im_q};
    assign bus.out_addr_t = at2_q;
    assign bus.out_addr_y = ay2_q;

`ifdef TWS_SAT_FLAG_EN
    logic sat_flag_q, sat_flag_d;

    // Sticky flag: a saturating beat entering S2 sets it and beats a same-cycle clear.
    always_comb begin
        sat_flag_d = sat_flag_q;
        if (sat_clr) begin
            sat_flag_d = 1'b0;
        end
        if (v1_q && en && (sat_re || sat_im)) begin
            sat_flag_d = 1'b1;
        end
    end

    // Status register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_flag_q <= 1'b0;
        end else begin
            sat_flag_q <= sat_flag_d;
        end
    end

    assign sat_flag = sat_flag_q;
`else
    // Saturation is still applied; only the status logic is left out.
    logic unused_sat;
    assign unused_sat = sat_re | sat_im;
`endif

endmodule

// File: tb/tb_bf_twiddle_scale.sv
// Scoreboard bench for bf_twiddle_scale: directed vectors with hand-worked results,
// a stall burst, reset with beats in flight, and a short model-checked random run.
module tb_bf_twiddle_scale;
    import fft_pkg::*;

    typedef struct {
        logic [31:0] t;
        logic [31:0] y;
        logic [9:0]  at;
        logic [9:0]  ay;
    } exp_t;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rstn;
    int   n_chk = 0;
    int   n_err = 0;
    int   ready_mode = 1;   // 0 low, 1 high, 2 random
    exp_t sb[$];

    logic        hold_vld = 1'b0;
    logic [31:0] hold_t, hold_y;

`ifdef TWS_SAT_FLAG_EN
    logic sat_flag;
    logic sat_clr = 1'b0;
`endif

    bf_twiddle_scale_if #(.COMP_BW(32), .N_LOG2(10)) bus ();

    bf_twiddle_scale dut (
        .clk      (clk),
        .rstn     (rstn),
`ifdef TWS_SAT_FLAG_EN
        .sat_flag (sat_flag),
        .sat_clr  (sat_clr),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [33:0] pk17(input int re, input int im);
        return {re[16:0], im[16:0]};
    endfunction

    function automatic logic [31:0] pk16(input int re, input int im);
        return {re[15:0], im[15:0]};
    endfunction

    function automatic longint clamp16(input longint x);
        if (x > SAT_MAX) return SAT_MAX;
        if (x < SAT_MIN) return SAT_MIN;
        return x;
    endfunction

    // Reference: ROM formula, round half-up over a 2^16 divide, saturate.
    function automatic void model(input int tr, input int ti, input int yr, input int yi,
                                  input int k, output logic [31:0] et, output logic [31:0] ey);
        real    ang;
        longint c, s, xr, xi;
        ang = 2.0 * PI * k / 1024.0;
        c = longint'($floor($cos(ang) * 32768.0 + 0.5));
        s = longint'($floor($sin(ang) * 32768.0 + 0.5));
        if (c > 32767) c = 32767;
        if (s > 32767) s = 32767;
        xr = (longint'(yr) * c + longint'(yi) * s + ROUND_HALF) >>> 16;
        xi = (longint'(yi) * c - longint'(yr) * s + ROUND_HALF) >>> 16;
        ey = pk16(int'(clamp16(xr)), int'(clamp16(xi)));
        et = pk16(int'((longint'(tr) + 1) >>> 1), int'((longint'(ti) + 1) >>> 1));
    endfunction

    task automatic send(input logic [33:0] t, input logic [33:0] y, input int k,
                        input int at, input int ay, input logic [31:0] et, input logic [31:0] ey);
        logic acc;
        exp_t e;
        acc = 1'b0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_t      = t;
        bus.in_y      = y;
        bus.in_tw_idx = 9'(k);
        bus.in_addr_t = 10'(at);
        bus.in_addr_y = 10'(ay);
        for (int c = 0; c < 200 && !acc; c++) begin
            #4;
            acc = bus.in_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        if (acc) begin
            e.t  = et;
            e.y  = ey;
            e.at = 10'(at);
            e.ay = 10'(ay);
            sb.push_back(e);
        end else begin
            n_chk++;
            n_err++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
        end
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 300 && sb.size() != 0; c++) @(posedge clk);
        #1 chk(nm, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: samples just before each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rstn) begin
                hold_vld = 1'b0;
            end else begin
                if (hold_vld) begin
                    chk("hold_valid", 64'(bus.out_valid), 64'd1);
                    chk("hold_t", 64'(bus.out_t), 64'(hold_t));
                    chk("hold_y", 64'(bus.out_y), 64'(hold_y));
                end
                hold_vld = 1'b0;
                if (bus.out_valid && !bus.out_ready) begin
                    chk("in_ready_stall", 64'(bus.in_ready), 64'd0);
                    hold_vld = 1'b1;
                    hold_t   = bus.out_t;
                    hold_y   = bus.out_y;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 64'(bus.out_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_t", 64'(bus.out_t), 64'(e.t));
                        chk("out_y", 64'(bus.out_y), 64'(e.y));
                        chk("out_addr_t", 64'(bus.out_addr_t), 64'(e.at));
                        chk("out_addr_y", 64'(bus.out_addr_y), 64'(e.ay));
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] et, ey;
        int a, b, c, d;
        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_t      = '0;
        bus.in_y      = '0;
        bus.in_tw_idx = '0;
        bus.in_addr_t = '0;
        bus.in_addr_y = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_t", 64'(bus.out_t), 64'd0);
        chk("rst_out_y", 64'(bus.out_y), 64'd0);
        chk("rst_out_addr", 64'({bus.out_addr_t, bus.out_addr_y}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed: identity twiddle, quarter turn, eighth turn with saturation.
        send(pk17(301, -3), pk17(200, -100), 0, 5, 517, pk16(151, -1), pk16(100, -50));
        send(pk17(0, 0), pk17(200, -100), 256, 6, 518, pk16(0, 0), pk16(-50, -100));
        send(pk17(1000, -1000), pk17(65535, 65535), 128, 7, 519,
             pk16(500, -500), pk16(32767, 0));
        drain("drain_directed");
`ifdef TWS_SAT_FLAG_EN
        chk("sat_flag_set", 64'(sat_flag), 64'd1);
        @(negedge clk);
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        chk("sat_flag_clr", 64'(sat_flag), 64'd0);
`endif

        // Back-to-back burst with a three-cycle downstream stall.
        // k=0, Y=(2m,-2m) gives (m,-m); T=(2m+1,2m-1) gives (m+1,m).
        fork
            for (int m = 1; m <= 8; m++) begin
                send(pk17(2*m + 1, 2*m - 1), pk17(2*m, -2*m), 0, m, m + 512,
                     pk16(m + 1, m), pk16(m, -m));
            end
            begin
                repeat (4) @(posedge clk);
                #1 ready_mode = 0;
                repeat (3) @(posedge clk);
                #1 ready_mode = 1;
            end
        join
        drain("drain_stall");

        // Reset with three beats stuck in the pipeline.
        @(posedge clk);
        #1 ready_mode = 0;
        for (int m = 0; m < 3; m++) begin
            send(pk17(10, 10), pk17(20, 20), 0, 100 + m, 200 + m, pk16(5, 5), pk16(10, 10));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_out_t", 64'(bus.out_t), 64'd0);
        chk("midrst_out_y", 64'(bus.out_y), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        ready_mode = 1;
        repeat (2 * TWS_LAT + 4) @(posedge clk);
        #1 chk("post_rst_no_beat", 64'(bus.out_valid), 64'd0);

        // Random operands against the reference model, random downstream ready.
        ready_mode = 2;
        for (int i = 0; i < 150; i++) begin
            a = int'($urandom_range(0, 65535)) - 32768;
            b = int'($urandom_range(0, 65535)) - 32768;
            c = int'($urandom_range(0, 65535)) - 32768;
            d = int'($urandom_range(0, 65535)) - 32768;
            model(a + b, c + d, a - b, c - d, i * 37 % 512, et, ey);
            send(pk17(a + b, c + d), pk17(a - b, c - d), i * 37 % 512, i, 1023 - i, et, ey);
        end
        drain("drain_random");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
